msrv32_store_unit: RTL and testbench
====================================

# msrv32_store_unit

Store path of the RV32I data-memory interface, sitting between the execute stage and the AHB-Lite data port. It accepts SB/SH/SW requests from the core, replicates store data across byte lanes, and generates the byte write mask. It runs a single-transfer AHB write (address phase, then data phase) with wait-state handling. Completion, bus error, and misalignment are reported back to the core as one-cycle pulses.

## Interface
Parameters: none.

Ports:
- ms_riscv32_mp_clk_in  input  1  system clock; all state updates on rising edge.
- ms_riscv32_mp_rst_in  input  1  reset, synchronous, active-high.
- store_req_in  input  1  core requests a store this cycle; sampled only in IDLE.
- store_size_in  input  2  00 byte, 01 half, 10 word, 11 treated as word.
- iadder_in  input  32  effective byte address.
- rs2_in  input  32  store data, right-justified.
- ahb_ready_in  input  1  HREADY; phase completes when high.
- ahb_resp_in  input  1  HRESP; 1 = error, sampled at data-phase completion.
- ms_riscv32_mp_dmaddr_out  output  32  HADDR = {addr[31:2],2'b00}.
- ms_riscv32_mp_dmdata_out  output  32  HWDATA, lane-replicated.
- ms_riscv32_mp_dmwr_mask_out  output  4  byte-lane write strobes.
- ms_riscv32_mp_dmwr_req_out  output  1  HWRITE/valid, high in ADDR only.
- ahb_htrans_out  output  2  00 IDLE, 10 NONSEQ.
- store_busy_out  output  1  high whenever state != IDLE.
- store_done_out  output  1  one-cycle pulse, store completed without error.
- store_err_out  output  1  one-cycle pulse, bus error response.
- misaligned_store_out  output  1  one-cycle pulse, request rejected.

## Operation
- FSM states: IDLE, ADDR, DATA.
- IDLE: when store_req_in=1, the block checks alignment.
  - Misaligned cases: half with addr[0]=1; word or size 11 with addr[1:0]!=00.
  - If misaligned, misaligned_store_out pulses the next cycle, no bus activity occurs, and the FSM stays in IDLE.
  - If aligned, address, mask, and data are captured into registers and the FSM goes to ADDR.
- ADDR: htrans=10, dmwr_req=1, addr and mask are driven. Go to DATA when ahb_ready_in=1; otherwise hold every output unchanged.
- DATA: htrans=00, dmwr_req=0, and dmdata holds the captured data. Addr and mask are held from ADDR.
  - Stay in DATA while ahb_ready_in=0.
  - On ahb_ready_in=1, go to IDLE. Pulse store_err_out if ahb_resp_in=1, else pulse store_done_out.
- Data replication:
  - byte → {4{rs2[7:0]}}
  - half → {2{rs2[15:0]}}
  - word → rs2
- Mask:
  - byte → 4'b0001 << addr[1:0]
  - half → addr[1] ? 4'b1100 : 4'b0011
  - word → 4'b1111
- store_req_in while busy is ignored; the core must stall on store_busy_out.
- All outputs are registered.

## Timing
- Reset (synchronous): at the next edge with rst=1, the state is IDLE and every output is 0, including htrans=00, mask=0000, data=0, and addr=0. Reset mid-transfer aborts without any done or err pulse.
- Minimum latency, with the request sampled at edge E0:
  - ADDR is visible cycle 1.
  - DATA is visible cycle 2, with ready=1.
  - done pulses in cycle 3, the IDLE cycle.
- Each wait state (ready=0) adds one cycle to the phase in which it occurs.
- In the done/err cycle the FSM is already IDLE, so a new store_req_in sampled in that cycle is accepted (back-to-back stores, one every 3 cycles minimum).
- The misaligned pulse appears in the cycle after the request sample; store_busy_out stays 0 throughout.
- In IDLE: htrans=00, dmwr_req=0, busy=0. The data, addr, and mask registers retain their last values, except after reset.

## Test plan
- Reset: assert rst for 2 cycles during a DATA wait state → the next cycle shows IDLE, all outputs 0, and no done pulse.
- SB addr 0x1003, rs2 0xAABBCCDD, ready=1 → cycle 1: addr 0x1000, mask 1000, htrans 10, dmwr_req 1. Cycle 2: data 0xDDDDDDDD. Cycle 3: done=1.
- SH addr 0x2002, rs2 0x00001234, ready low for 2 cycles in ADDR then 1 cycle in DATA → mask 1100 and data 0x12341234. Outputs are held across the waits; done arrives 3 cycles later than the no-wait case.
- SW addr 0x3001 → misaligned pulse the next cycle, htrans stays 00, busy 0. The same test covers SH at 0x3001.
- SW addr 0x4000, rs2 0xCAFEF00D, with resp=1 at DATA ready → store_err_out=1 and store_done_out=0; the FSM returns to IDLE.
- Back-to-back: SW 0x10 then SB 0x15 (rs2 0x5A) requested in the done cycle → the second transfer starts the next cycle with mask 0010 and data 0x5A5A5A5A.

Source files
------------

// File: rtl/msrv32_store_unit.sv
// rtl/msrv32_store_unit.sv - RV32I store path driving a single-transfer AHB-Lite write
module msrv32_store_unit (
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_in,
    input  logic        store_req_in,
    input  logic [1:0]  store_size_in,
    input  logic [31:0] iadder_in,
    input  logic [31:0] rs2_in,
    input  logic        ahb_ready_in,
    input  logic        ahb_resp_in,
    output logic [31:0] ms_riscv32_mp_dmaddr_out,
    output logic [31:0] ms_riscv32_mp_dmdata_out,
    output logic [3:0]  ms_riscv32_mp_dmwr_mask_out,
    output logic        ms_riscv32_mp_dmwr_req_out,
    output logic [1:0]  ahb_htrans_out,
    output logic        store_busy_out,
    output logic        store_done_out,
    output logic        store_err_out,
    output logic        misaligned_store_out
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ADDR = 2'b01,
        DATA = 2'b10
    } state_t;

    state_t      state;
    state_t      next_state;
    logic        req_misaligned;
    logic [3:0]  req_mask;
    logic [31:0] req_data;
    logic [31:0] data_q;
    logic        accept;

    // Decode the incoming request: lane mask, replicated data and alignment check
    always_comb begin
        req_misaligned = 1'b0;
        req_mask       = 4'b1111;
        req_data       = rs2_in;
        case (store_size_in)
            2'b00: begin
                req_mask = 4'b0001 << iadder_in[1:0];
                req_data = {4{rs2_in[7:0]}};
            end
            2'b01: begin
                req_misaligned = iadder_in[0];
                req_mask       = iadder_in[1] ? 4'b1100 : 4'b0011;
                req_data       = {2{rs2_in[15:0]}};
            end
            default: begin
                req_misaligned = |iadder_in[1:0];
            end
        endcase
    end

    // Requests are only honoured in IDLE; busy-time requests are dropped
    assign accept = (state == IDLE) && store_req_in && !req_misaligned;

    // State register
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: each bus phase advances only on HREADY
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = ADDR;
            ADDR:    if (ahb_ready_in) next_state = DATA;
            DATA:    if (ahb_ready_in) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Registered outputs, computed from the state being entered so they line up with it
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            ms_riscv32_mp_dmaddr_out    <= 32'd0;
            ms_riscv32_mp_dmdata_out    <= 32'd0;
            ms_riscv32_mp_dmwr_mask_out <= 4'd0;
            ms_riscv32_mp_dmwr_req_out  <= 1'b0;
            ahb_htrans_out              <= 2'b00;
            store_busy_out              <= 1'b0;
            store_done_out              <= 1'b0;
            store_err_out               <= 1'b0;
            misaligned_store_out        <= 1'b0;
            data_q                      <= 32'd0;
        end else begin
            ahb_htrans_out             <= (next_state == ADDR) ? 2'b10 : 2'b00;
            ms_riscv32_mp_dmwr_req_out <= (next_state == ADDR);
            store_busy_out             <= (next_state != IDLE);
            store_done_out             <= (state == DATA) && ahb_ready_in && !ahb_resp_in;
            store_err_out              <= (state == DATA) && ahb_ready_in && ahb_resp_in;
            misaligned_store_out       <= (state == IDLE) && store_req_in && req_misaligned;
            if (accept) begin
                ms_riscv32_mp_dmaddr_out    <= {iadder_in[31:2], 2'b00};
                ms_riscv32_mp_dmwr_mask_out <= req_mask;
                data_q                      <= req_data;
            end
            // HWDATA is presented only once the data phase begins
            if ((state == ADDR) && ahb_ready_in) begin
                ms_riscv32_mp_dmdata_out <= data_q;
            end
        end
    end

endmodule

// File: tb/tb_msrv32_store_unit.sv
// tb/tb_msrv32_store_unit.sv - scoreboard bench for msrv32_store_unit
module tb_msrv32_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        store_req;
    logic [1:0]  store_size;
    logic [31:0] iadder;
    logic [31:0] rs2;
    logic        ready;
    logic        resp;
    logic [31:0] dmaddr;
    logic [31:0] dmdata;
    logic [3:0]  dmmask;
    logic        dmwr_req;
    logic [1:0]  htrans;
    logic        busy;
    logic        done;
    logic        err;
    logic        mis;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [1:0]  kind;   // 0 done, 1 err, 2 misaligned
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    msrv32_store_unit dut (
        .ms_riscv32_mp_clk_in        (clk),
        .ms_riscv32_mp_rst_in        (rst),
        .store_req_in                (store_req),
        .store_size_in               (store_size),
        .iadder_in                   (iadder),
        .rs2_in                      (rs2),
        .ahb_ready_in                (ready),
        .ahb_resp_in                 (resp),
        .ms_riscv32_mp_dmaddr_out    (dmaddr),
        .ms_riscv32_mp_dmdata_out    (dmdata),
        .ms_riscv32_mp_dmwr_mask_out (dmmask),
        .ms_riscv32_mp_dmwr_req_out  (dmwr_req),
        .ahb_htrans_out              (htrans),
        .store_busy_out              (busy),
        .store_done_out              (done),
        .store_err_out               (err),
        .misaligned_store_out        (mis)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] model_mask(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'b00) return (a[1:0] == 2'd0) ? 4'b0001 : (a[1:0] == 2'd1) ? 4'b0010 :
                                (a[1:0] == 2'd2) ? 4'b0100 : 4'b1000;
        if (sz == 2'b01) return a[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] model_data(input logic [1:0] sz, input logic [31:0] d);
        if (sz == 2'b00) return {d[7:0], d[7:0], d[7:0], d[7:0]};
        if (sz == 2'b01) return {d[15:0], d[15:0]};
        return d;
    endfunction

    // Scoreboard: every completion-type pulse must match the oldest expected result
    always @(negedge clk) begin
        if (!rst && (done || err || mis)) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", {29'd0, mis, err, done}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("pulse_done", {31'd0, done}, {31'd0, e.kind == 2'd0});
                check("pulse_err",  {31'd0, err},  {31'd0, e.kind == 2'd1});
                check("pulse_mis",  {31'd0, mis},  {31'd0, e.kind == 2'd2});
                check("end_busy",   {31'd0, busy}, 32'd0);
                if (e.kind != 2'd2) begin
                    check("sb_addr", dmaddr, e.addr);
                    check("sb_mask", {28'd0, dmmask}, {28'd0, e.mask});
                    check("sb_data", dmdata, e.data);
                end
            end
        end
    end

    // Called at a negedge; ends at the negedge of the done/err cycle
    task automatic do_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                            input int aw, input int dw, input logic r);
        exp_t e;
        logic [31:0] ea;
        logic [3:0]  em;
        logic [31:0] ed;
        ea = {a[31:2], 2'b00};
        em = model_mask(sz, a);
        ed = model_data(sz, d);
        e.kind = r ? 2'd1 : 2'd0; e.addr = ea; e.mask = em; e.data = ed;
        sb.push_back(e);
        store_req = 1'b1; store_size = sz; iadder = a; rs2 = d; ready = 1'b0; resp = 1'b0;
        @(negedge clk);
        store_req = 1'b0; iadder = 32'hDEAD_BEEF; rs2 = 32'h0BAD_0BAD;
        check("addr_htrans", {30'd0, htrans}, 32'd2);
        check("addr_wr_req", {31'd0, dmwr_req}, 32'd1);
        check("addr_addr", dmaddr, ea);
        check("addr_mask", {28'd0, dmmask}, {28'd0, em});
        check("addr_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < aw; i++) begin
            ready = 1'b0;
            @(negedge clk);
            check("await_htrans", {30'd0, htrans}, 32'd2);
            check("await_addr", dmaddr, ea);
            check("await_mask", {28'd0, dmmask}, {28'd0, em});
        end
        ready = 1'b1;
        @(negedge clk);
        check("data_htrans", {30'd0, htrans}, 32'd0);
        check("data_wr_req", {31'd0, dmwr_req}, 32'd0);
        check("data_data", dmdata, ed);
        check("data_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < dw; i++) begin
            ready = 1'b0;
            @(negedge clk);
            check("dwait_data", dmdata, ed);
            check("dwait_done", {31'd0, done | err}, 32'd0);
        end
        ready = 1'b1; resp = r;
        @(negedge clk);
        ready = 1'b0; resp = 1'b0;
        check("end_pulse", {31'd0, done | err}, 32'd1);
    endtask

    task automatic do_misaligned(input logic [1:0] sz, input logic [31:0] a);
        exp_t e;
        e.kind = 2'd2; e.addr = 32'd0; e.mask = 4'd0; e.data = 32'd0;
        sb.push_back(e);
        store_req = 1'b1; store_size = sz; iadder = a; rs2 = 32'h1111_2222;
        @(negedge clk);
        store_req = 1'b0;
        check("mis_pulse", {31'd0, mis}, 32'd1);
        check("mis_htrans", {30'd0, htrans}, 32'd0);
        check("mis_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("mis_one_cycle", {31'd0, mis}, 32'd0);
        check("mis_htrans2", {30'd0, htrans}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; store_req = 1'b0; store_size = 2'b10; iadder = 32'd0; rs2 = 32'd0;
        ready = 1'b0; resp = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_htrans", {30'd0, htrans}, 32'd0);
        check("rst_addr", dmaddr, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // SB, no waits
        do_store(2'b00, 32'h0000_1003, 32'hAABB_CCDD, 0, 0, 1'b0);
        @(negedge clk);
        // SH with 2 address waits and 1 data wait
        do_store(2'b01, 32'h0000_2002, 32'h0000_1234, 2, 1, 1'b0);
        @(negedge clk);
        // Misaligned word and half
        do_misaligned(2'b10, 32'h0000_3001);
        do_misaligned(2'b01, 32'h0000_3001);
        do_misaligned(2'b11, 32'h0000_3002);
        // Bus error
        do_store(2'b10, 32'h0000_4000, 32'hCAFE_F00D, 0, 0, 1'b1);
        @(negedge clk);
        check("post_err_busy", {31'd0, busy}, 32'd0);
        // Back-to-back, second request driven in the done cycle
        do_store(2'b10, 32'h0000_0010, 32'h1357_9BDF, 0, 0, 1'b0);
        do_store(2'b00, 32'h0000_0015, 32'h0000_005A, 0, 0, 1'b0);
        // Size 11 at an aligned address, plus byte/half lane variations
        do_store(2'b11, 32'h0000_5004, 32'h8765_4321, 1, 0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            do_store(2'b00, 32'h0000_6000 + i, $urandom, $urandom_range(0, 1), $urandom_range(0, 1), 1'b0);
        end
        do_store(2'b01, 32'h0000_7000, 32'hFFFF_ABCD, 0, 0, 1'b0);
        @(negedge clk);

        // Reset during a data-phase wait state
        store_req = 1'b1; store_size = 2'b10; iadder = 32'h0000_8000; rs2 = 32'h2468_ACE0;
        @(negedge clk);
        store_req = 1'b0; ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        @(negedge clk);
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_data", dmdata, 32'd0);
        check("mid_rst_addr", dmaddr, 32'd0);
        check("mid_rst_mask", {28'd0, dmmask}, 32'd0);
        ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_done", {29'd0, mis, err, done}, 32'd0);
        check("post_rst_htrans", {30'd0, htrans}, 32'd0);
        check("post_rst_wr_req", {31'd0, dmwr_req}, 32'd0);
        ready = 1'b0;
        repeat (2) @(negedge clk);
        check("sb_empty", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
